// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for pipeline stage registers: slot operation encoding
// and the EX/MEM bundle layout used to build that boundary's bubble value.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_op_t;

  localparam logic [3:0] REG_INVALID = 4'hF;

  // EX/MEM bundle, LSB first: rwe2, memdata16, wreg4, data16, pc16, instr16
  localparam int EXMEM_W     = 70;
  localparam int RWE_LSB     = 0;
  localparam int RWE_W       = 2;
  localparam int MEMDATA_LSB = 2;
  localparam int MEMDATA_W   = 16;
  localparam int WREG_LSB    = 18;
  localparam int WREG_W      = 4;
  localparam int DATA_LSB    = 22;
  localparam int DATAF_W     = 16;
  localparam int PC_LSB      = 38;
  localparam int PC_W        = 16;
  localparam int INSTR_LSB   = 54;
  localparam int INSTR_W     = 16;

  // Bubble for the EX/MEM boundary: everything zero except wreg, which is
  // marked invalid so a bubble never writes the register file.
  localparam logic [EXMEM_W-1:0] BUBBLE_EXMEM = {48'h0, REG_INVALID, 18'h0};

  function automatic logic [WREG_W-1:0] exmem_wreg(input logic [EXMEM_W-1:0] b);
    return b[WREG_LSB +: WREG_W];
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline slot: payload register plus valid bit. Clear wins over load;
// an empty slot always holds the bubble value, never stale contents.
module pipe_stage_slot
  import pipe_stage_skid_pkg::*;
#(
  parameter int                 DATA_W = 70,
  parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Slot state: async reset to empty/bubble, then clear > load > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with valid/ready handshake, synchronous flush
// and a bubble value. SKID=0 is a single slot with combinational ready;
// SKID=1 adds a skid slot so upstream ready is a pure register output.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W = 70,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int                SKID   = 0
) (
  input  logic              psi_clk,
  input  logic              psi_rst,
  input  logic              psi_flush,
  input  logic              psi_valid,
  input  logic [DATA_W-1:0] psi_data,
  output logic              pso_ready_up,
  output logic              pso_valid,
  output logic [DATA_W-1:0] pso_data,
  input  logic              psi_ready_dn,
  output logic [1:0]        pso_count
);

  logic              push;
  logic              pop;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;

  assign push = psi_valid & pso_ready_up;
  assign pop  = m_valid & psi_ready_dn;

  generate
    if (SKID != 0) begin : g_skid
      logic              s_valid;
      logic [DATA_W-1:0] s_data;
      logic [DATA_W-1:0] m_din;
      slot_op_t          m_op;
      slot_op_t          s_op;

      // Slot sequencing: flush kills both; a popping main refills from skid
      // first so ordering stays FIFO; a push lands in main if it frees up,
      // otherwise in skid.
      always_comb begin
        m_op = SLOT_HOLD;
        s_op = SLOT_HOLD;
        if (psi_flush) begin
          m_op = SLOT_CLEAR;
          s_op = SLOT_CLEAR;
        end else if (pop && s_valid) begin
          m_op = SLOT_LOAD;
          s_op = SLOT_CLEAR;
        end else if (push && (!m_valid || pop)) begin
          m_op = SLOT_LOAD;
        end else if (push) begin
          s_op = SLOT_LOAD;
        end else if (pop) begin
          m_op = SLOT_CLEAR;
        end
      end

      assign m_din        = s_valid ? s_data : psi_data;
      assign pso_ready_up = ~s_valid;
      assign pso_count    = {1'b0, m_valid} + {1'b0, s_valid};

      // ---- main (output) slot ----
      pipe_stage_slot #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_main (
        .clk   (psi_clk),
        .rst   (psi_rst),
        .load  (m_op == SLOT_LOAD),
        .clear (m_op == SLOT_CLEAR),
        .din   (m_din),
        .valid (m_valid),
        .data  (m_data)
      );

      // ---- skid slot ----
      pipe_stage_slot #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
        .clk   (psi_clk),
        .rst   (psi_rst),
        .load  (s_op == SLOT_LOAD),
        .clear (s_op == SLOT_CLEAR),
        .din   (psi_data),
        .valid (s_valid),
        .data  (s_data)
      );
    end else begin : g_single
      slot_op_t m_op;

      // Single slot: flush > push (refill, may overlap a pop) > pop > hold.
      always_comb begin
        m_op = SLOT_HOLD;
        if (psi_flush)  m_op = SLOT_CLEAR;
        else if (push)  m_op = SLOT_LOAD;
        else if (pop)   m_op = SLOT_CLEAR;
      end

      assign pso_ready_up = ~m_valid | psi_ready_dn;
      assign pso_count    = {1'b0, m_valid};

      // ---- main (output) slot ----
      pipe_stage_slot #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_main (
        .clk   (psi_clk),
        .rst   (psi_rst),
        .load  (m_op == SLOT_LOAD),
        .clear (m_op == SLOT_CLEAR),
        .din   (psi_data),
        .valid (m_valid),
        .data  (m_data)
      );
    end
  endgenerate

  assign pso_valid = m_valid;
  assign pso_data  = m_valid ? m_data : BUBBLE;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register that succeeds the fixed-bundle inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W payload with a valid/ready handshake, synchronous flush and a defined bubble value.
- Optional 2-entry skid buffer (SKID=1) registers the upstream ready, breaking the combinational stall path through the CPU pipeline.
- Instantiated once per pipeline boundary; stall ("keep") is expressed as psi_ready_dn=0.

Parameters:
- DATA_W, 70, payload width (EX/MEM bundle: instr16+pc16+data16+wreg4+memdata16+rwe2).
- BUBBLE, {DATA_W{1'b0}}, payload presented when the output is not valid. The integrator sets the wreg field to REG_INVALID.
- SKID, 0, 0 = single register with combinational ready; 1 = main+skid register pair with registered ready.

Ports:
- psi_clk  in  1  clock, all state on rising edge
- psi_rst  in  1  asynchronous, active-high reset
- psi_flush  in  1  synchronous flush (branch/exception kill)
- psi_valid  in  1  upstream payload valid
- psi_data  in  DATA_W  upstream payload
- pso_ready_up  out  1  stage can accept this cycle
- pso_valid  out  1  downstream payload valid
- pso_data  out  DATA_W  downstream payload; equals BUBBLE when pso_valid=0
- psi_ready_dn  in  1  downstream accepts (0 = keep/stall)
- pso_count  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1)

Behaviour:
- Reset (async, psi_rst=1): all entries invalid, pso_valid=0, pso_data=BUBBLE, pso_count=0, pso_ready_up=1. Reset is released synchronously into the clock domain by the integrator.
- Handshake terms: push = psi_valid & pso_ready_up; pop = pso_valid & psi_ready_dn. psi_data must be stable while psi_valid=1 and ready=0.
- Latency: push at edge N gives pso_valid=1 after edge N, for both SKID values.
- SKID=0, one slot M:
  - pso_ready_up = !M.v | psi_ready_dn (combinational).
  - At each edge: if push, M <= psi_data and v=1; else if pop, v=0; else hold.
- SKID=1, slots M (output) and S (skid):
  - pso_ready_up = !S.v (registered, no combinational path from psi_ready_dn).
  - M empty, or M popping with S empty: push loads M.
  - M full, not popping, push: load S.
  - M popping with S full: S moves to M and S clears. A push cannot occur in the same cycle because ready_up=0.
  - M popping, S empty, no push: M clears.
  - Ordering is strictly FIFO. No entry is lost or duplicated.
- Flush: at the edge, all entries are invalidated and pso_count=0. A simultaneous push is discarded and a simultaneous pop still completes downstream. Flush has priority over push, pop and hold.
- When pso_valid=0, pso_data is driven to BUBBLE, never to stale contents.
- pso_count = M.v + S.v, registered.
- Reset asserted mid-transfer: payloads are dropped and outputs go to reset values immediately (asynchronous).

Decomposition:
- Shared package/defines: REG_INVALID, EX/MEM field offsets and widths, and a BUBBLE_EXMEM constant with the wreg field = REG_INVALID. The block itself stays payload-agnostic.
- One sub-module, pipe_stage_slot: a DATA_W register plus valid bit, with load/clear/hold and async reset to BUBBLE. Instantiate once for SKID=0 and twice for SKID=1 via generate.

Test Plan:
- Reset: assert psi_rst with psi_valid=1, data=0x1234 -> pso_valid=0, pso_data=BUBBLE, count=0, ready_up=1. First push after release appears one edge later.
- Streaming (both SKID values): push 0x1..0x8 on consecutive cycles with ready_dn=1 -> outputs 0x1..0x8 on consecutive cycles, latency 1, no gaps.
- Stall (SKID=1): ready_dn=0 while pushing A, B, C -> A held, B in skid, ready_up=0 after B, C not accepted, count=2. ready_dn=1 -> A, B, C in order.
- Stall (SKID=0): ready_dn=0 with A held -> ready_up=0 in the same cycle and A held for 5 cycles. Release -> A popped and a new push accepted in the same edge.
- Flush with count=2 and simultaneous push D -> next cycle pso_valid=0, pso_data=BUBBLE (wreg=REG_INVALID), count=0. D is never output.
- Random valid/ready over 10k cycles against a reference queue -> order preserved, no loss or duplication, count matches the model, and pso_ready_up has no combinational dependency on psi_ready_dn when SKID=1.
